lru_tracker: RTL and testbench
==============================

LRU_TRACKER -- requirements
Module: lru_tracker

Interface
REQ-001 SHALL have parameter WAYS, default 8, meaning associativity; power of two, 2..16.
REQ-002 SHALL have parameter SETS, default 8, meaning number of sets; power of two, 2..256.
REQ-003 SHALL define WB = $clog2(WAYS) and SB = $clog2(SETS) as derived localparams.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port use_valid, input, 1 bit: a way was used (hit or fill) this cycle.
REQ-007 SHALL have port use_set, input, SB bits: set of the use.
REQ-008 SHALL have port use_way, input, WB bits: encoded way of the use.
REQ-009 SHALL have port inv_valid, input, 1 bit: invalidate one way this cycle.
REQ-010 SHALL have ports inv_set (SB bits) and inv_way (WB bits), inputs: target of the invalidate.
REQ-011 SHALL have port flush_req, input, 1 bit: start a whole-array flush.
REQ-012 SHALL have port lookup_set, input, SB bits: set whose victim is reported.
REQ-013 SHALL have port victim_way, output, WB bits: way to replace in lookup_set.
REQ-014 SHALL have port set_full, output, 1 bit: all ways of lookup_set are valid.
REQ-015 SHALL have port busy, output, 1 bit: flush in progress.
REQ-016 SHALL have port inv_dropped, output, 1 bit: registered one-cycle pulse, invalidate discarded.

Function
REQ-017 SHALL keep per set a recency stack of WAYS entries (position 0 = MRU, WAYS-1 = LRU) and a WAYS-bit valid mask.
REQ-018 Use, when busy=0: way at position p moves to position 0; positions 0..p-1 shift down by one; others unchanged; valid bit set.
REQ-019 Use of the way already at MRU SHALL leave the order unchanged and set its valid bit.
REQ-020 Invalidate, when busy=0: way moves to position WAYS-1; entries below its old position shift up by one; valid bit cleared.
REQ-021 Simultaneous use and invalidate to different sets SHALL both apply in the same cycle.
REQ-022 Simultaneous use and invalidate to the same set SHALL apply the use only; the invalidate is discarded and inv_dropped=1 the next cycle.
REQ-023 victim_way SHALL be the lowest-numbered invalid way of lookup_set if one exists, else the way at position WAYS-1; combinational from state.
REQ-024 set_full SHALL be the AND of lookup_set's valid mask, combinational from state.
REQ-025 An update SHALL be visible on victim_way/set_full in the cycle after its edge; there is no same-cycle bypass.
REQ-026 FSM IDLE->FLUSH when flush_req=1 in IDLE; FLUSH clears one set per cycle starting at set 0; after set SETS-1 it returns to IDLE.
REQ-027 A flush SHALL take exactly SETS cycles; busy=1 throughout FLUSH, including the cycle the last set clears.
REQ-028 A flushed set SHALL hold initial order (position i holds way WAYS-1-i) with valid mask 0.
REQ-029 While busy=1, use and invalidate SHALL be ignored; flush_req SHALL be ignored; inv_valid additionally pulses inv_dropped.

Reset
REQ-030 rst_n=0 SHALL immediately put every set in initial order, clear all valid masks, and set FSM=IDLE, flush counter=0, inv_dropped=0.
REQ-031 Consequently victim_way=0, set_full=0, busy=0 during and after reset; assertion mid-flush SHALL abort the flush.

Structure
REQ-032 SHALL place lru_way_t, lru_set_t and the flush FSM state enum in package cache_types; WAYS/SETS defaults SHALL be constants there.
REQ-033 SHALL use one sub-module, lru_stack_update: combinational next-order/next-valid for one set given use or invalidate.
REQ-034 Storage SHALL be flip-flops, not inferred RAM.

Verification (WAYS=4, SETS=8)
REQ-035 Reset, lookup_set=3 -> victim_way=0, set_full=0, busy=0.
REQ-036 Uses in set 2 of ways 0,1,2,3, then use of way 0 -> stack 0,3,2,1, set_full=1, victim_way=1.
REQ-037 Same state, invalidate set 2 way 3 -> stack 0,2,1,3, set_full=0, victim_way=3.
REQ-038 Use set 5 way 1 and invalidate set 5 way 2 in the same cycle -> way 1 is MRU, way 2 still valid, inv_dropped=1 for one cycle.
REQ-039 flush_req with all sets full -> busy high exactly 8 cycles, a use during busy has no effect, afterwards every set reports victim_way=0, set_full=0.
REQ-040 rst_n low in the 4th flush cycle -> busy=0 immediately; all sets in initial order, all valid masks 0.

Source files
------------

// File: rtl/lru_tracker_pkg.sv
// cache_types: shared LRU tracker types, defaults and flush FSM states.
package cache_types;
    localparam int LRU_WAYS_DEF = 8;
    localparam int LRU_SETS_DEF = 8;
    localparam int LRU_WB_MAX = 4;
    localparam int LRU_SB_MAX = 8;
    typedef logic [LRU_WB_MAX-1:0] lru_way_t;
    typedef logic [LRU_SB_MAX-1:0] lru_set_t;
    typedef enum logic {ST_IDLE, ST_FLUSH} flush_st_t;
endpackage

// File: rtl/lru_tracker_stack_update.sv
// lru_stack_update: next recency order and valid mask of one set for a use or an invalidate.
module lru_stack_update
    import cache_types::*;
#(
    parameter int WAYS = LRU_WAYS_DEF,
    localparam int WB = $clog2(WAYS)
) (
    input  logic [WAYS-1:0][WB-1:0] order_in,
    input  logic [WAYS-1:0]         valid_in,
    input  logic                    do_use,
    input  logic                    do_inv,
    input  logic [WB-1:0]           way,
    output logic [WAYS-1:0][WB-1:0] order_out,
    output logic [WAYS-1:0]         valid_out
);
    lru_way_t pos;
    logic [WAYS-1:0] onehot;
    assign onehot = WAYS'(1) << way;
    assign valid_out = do_use ? valid_in | onehot : do_inv ? valid_in & ~onehot : valid_in;
    always_comb begin
        pos = '0;
        for (int i = 0; i < WAYS; i++)
            if (order_in[i] == way) pos = lru_way_t'(i);
        order_out = order_in;
        if (do_use) begin
            order_out[0] = way;
            for (int i = 1; i < WAYS; i++)
                if (lru_way_t'(i) <= pos) order_out[i] = order_in[i-1];
        end else if (do_inv) begin
            order_out[WAYS-1] = way;
            for (int i = 0; i < WAYS-1; i++)
                if (lru_way_t'(i) >= pos) order_out[i] = order_in[i+1];
        end
    end
endmodule

// File: rtl/lru_tracker.sv
// lru_tracker: per-set true-LRU recency stacks with valid masks, victim lookup and sequential flush.
module lru_tracker
    import cache_types::*;
#(
    parameter int WAYS = LRU_WAYS_DEF,
    parameter int SETS = LRU_SETS_DEF,
    localparam int WB = $clog2(WAYS),
    localparam int SB = $clog2(SETS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          use_valid,
    input  logic [SB-1:0] use_set,
    input  logic [WB-1:0] use_way,
    input  logic          inv_valid,
    input  logic [SB-1:0] inv_set,
    input  logic [WB-1:0] inv_way,
    input  logic          flush_req,
    input  logic [SB-1:0] lookup_set,
    output logic [WB-1:0] victim_way,
    output logic          set_full,
    output logic          busy,
    output logic          inv_dropped
);
    logic [WAYS-1:0][WB-1:0] order_q [SETS];
    logic [WAYS-1:0]         valid_q [SETS];
    logic [WAYS-1:0][WB-1:0] use_order, inv_order;
    logic [WAYS-1:0]         use_mask, inv_mask;
    flush_st_t state;
    lru_set_t  flush_cnt;
    logic      conflict;

    assign busy = state == ST_FLUSH;
    assign conflict = use_valid && use_set == inv_set;
    assign set_full = &valid_q[lookup_set];

    lru_stack_update #(.WAYS(WAYS)) u_use (
        .order_in(order_q[use_set]), .valid_in(valid_q[use_set]),
        .do_use(1'b1), .do_inv(1'b0), .way(use_way),
        .order_out(use_order), .valid_out(use_mask)
    );
    lru_stack_update #(.WAYS(WAYS)) u_inv (
        .order_in(order_q[inv_set]), .valid_in(valid_q[inv_set]),
        .do_use(1'b0), .do_inv(1'b1), .way(inv_way),
        .order_out(inv_order), .valid_out(inv_mask)
    );

    // Lowest invalid way wins; otherwise the LRU entry.
    always_comb begin
        victim_way = order_q[lookup_set][WAYS-1];
        for (int i = WAYS-1; i >= 0; i--)
            if (!valid_q[lookup_set][i]) victim_way = WB'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int i = 0; i < WAYS; i++) order_q[s][i] <= WB'(WAYS-1-i);
                valid_q[s] <= '0;
            end
            state <= ST_IDLE;
            flush_cnt <= '0;
            inv_dropped <= 1'b0;
        end else begin
            inv_dropped <= inv_valid && (busy || conflict);
            if (!busy) begin
                if (use_valid) begin
                    order_q[use_set] <= use_order;
                    valid_q[use_set] <= use_mask;
                end
                if (inv_valid && !conflict) begin
                    order_q[inv_set] <= inv_order;
                    valid_q[inv_set] <= inv_mask;
                end
                if (flush_req) begin
                    state <= ST_FLUSH;
                    flush_cnt <= '0;
                end
            end else begin
                for (int i = 0; i < WAYS; i++) order_q[flush_cnt[SB-1:0]][i] <= WB'(WAYS-1-i);
                valid_q[flush_cnt[SB-1:0]] <= '0;
                if (flush_cnt == lru_set_t'(SETS-1)) begin
                    state <= ST_IDLE;
                    flush_cnt <= '0;
                end else begin
                    flush_cnt <= flush_cnt + lru_set_t'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_lru_tracker.sv
// tb_lru_tracker: random and directed checks of lru_tracker against a queue-based recency model.
module tb_lru_tracker;
    logic       clk = 0, rst_n = 0;
    logic       use_valid = 0, inv_valid = 0, flush_req = 0;
    logic [2:0] use_set = 0, inv_set = 0, lookup_set = 0;
    logic [1:0] use_way = 0, inv_way = 0;
    logic [1:0] victim_way;
    logic       set_full, busy, inv_dropped;
    int total = 0, bad = 0;

    lru_tracker #(.WAYS(4), .SETS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .use_valid(use_valid), .use_set(use_set), .use_way(use_way),
        .inv_valid(inv_valid), .inv_set(inv_set), .inv_way(inv_way),
        .flush_req(flush_req), .lookup_set(lookup_set),
        .victim_way(victim_way), .set_full(set_full), .busy(busy), .inv_dropped(inv_dropped)
    );

    always #5 clk = ~clk;

    // Model: queue per set, front = MRU, back = LRU.
    int       stk [8][$];
    bit [3:0] mv [8];
    int       flush_left;
    bit       mdrop;

    function automatic void m_clear(input int s);
        stk[s] = '{3, 2, 1, 0};
        mv[s] = 4'h0;
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < 8; s++) m_clear(s);
        flush_left = 0;
        mdrop = 0;
    endfunction

    function automatic void m_remove(input int s, input int w);
        int k = -1;
        foreach (stk[s][i]) if (stk[s][i] == w) k = i;
        if (k >= 0) stk[s].delete(k);
    endfunction

    function automatic void m_step();
        if (flush_left == 0) begin
            mdrop = inv_valid && use_valid && use_set == inv_set;
            if (use_valid) begin
                m_remove(int'(use_set), int'(use_way));
                stk[use_set].push_front(int'(use_way));
                mv[use_set][use_way] = 1'b1;
            end
            if (inv_valid && !mdrop) begin
                m_remove(int'(inv_set), int'(inv_way));
                stk[inv_set].push_back(int'(inv_way));
                mv[inv_set][inv_way] = 1'b0;
            end
            if (flush_req) flush_left = 8;
        end else begin
            mdrop = inv_valid;
            m_clear(8 - flush_left);
            flush_left--;
        end
    endfunction

    function automatic int m_victim(input int s);
        for (int w = 0; w < 4; w++) if (!mv[s][w]) return w;
        return stk[s][3];
    endfunction

    function automatic int m_pack(input int s);
        int r = 0;
        for (int i = 0; i < 4; i++) r |= stk[s][i] << (2 * i);
        return r;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        use_valid = 0;
        inv_valid = 0;
        flush_req = 0;
    endtask

    task automatic cyc();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_set(input string tag, input int s);
        lookup_set = s[2:0];
        #1;
        chk({tag, "_victim"}, int'(victim_way), m_victim(s));
        chk({tag, "_full"}, int'(set_full), int'(mv[s] == 4'hF));
        chk({tag, "_order"}, int'(dut.order_q[s]), m_pack(s));
    endtask

    task automatic sweep(input string tag);
        for (int s = 0; s < 8; s++) check_set(tag, s);
    endtask

    initial begin
        int n;
        int seq [5] = '{0, 1, 2, 3, 0};
        m_reset();
        lookup_set = 3;
        #1;
        chk("rst_victim", int'(victim_way), 0);
        chk("rst_full", int'(set_full), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        foreach (seq[i]) begin
            use_valid = 1; use_set = 2; use_way = seq[i][1:0];
            cyc();
        end
        idle_in();
        check_set("use4", 2);
        chk("use4_stack", int'(dut.order_q[2]), 108);
        chk("use4_full_c", int'(set_full), 1);
        chk("use4_victim_c", int'(victim_way), 1);

        inv_valid = 1; inv_set = 2; inv_way = 3;
        cyc();
        idle_in();
        check_set("inv", 2);
        chk("inv_stack", int'(dut.order_q[2]), 216);
        chk("inv_victim_c", int'(victim_way), 3);

        use_valid = 1; use_set = 5; use_way = 2;
        cyc();
        inv_valid = 1; inv_set = 5; inv_way = 2; use_way = 1;
        cyc();
        idle_in();
        chk("conf_drop", int'(inv_dropped), 1);
        chk("conf_valid", int'(dut.valid_q[5]), 6);
        chk("conf_mru", int'(dut.order_q[5][0]), 1);
        check_set("conf", 5);
        cyc();
        chk("conf_drop_end", int'(inv_dropped), 0);

        for (int c = 0; c < 400; c++) begin
            use_valid = ($urandom_range(0, 3) != 0);
            use_set = 3'($urandom_range(0, 7));
            use_way = 2'($urandom_range(0, 3));
            inv_valid = ($urandom_range(0, 2) == 0);
            inv_set = ($urandom_range(0, 2) == 0) ? use_set : 3'($urandom_range(0, 7));
            inv_way = 2'($urandom_range(0, 3));
            flush_req = ($urandom_range(0, 49) == 0);
            lookup_set = ($urandom_range(0, 1) == 0) ? use_set : inv_set;
            cyc();
            chk("rnd_busy", int'(busy), int'(flush_left > 0));
            chk("rnd_drop", int'(inv_dropped), int'(mdrop));
            chk("rnd_victim", int'(victim_way), m_victim(int'(lookup_set)));
            chk("rnd_full", int'(set_full), int'(mv[lookup_set] == 4'hF));
            chk("rnd_order", int'(dut.order_q[lookup_set]), m_pack(int'(lookup_set)));
        end
        idle_in();
        while (flush_left > 0) cyc();

        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 4; w++) begin
                use_valid = 1; use_set = s[2:0]; use_way = w[1:0];
                cyc();
            end
        idle_in();
        check_set("fill", 6);
        flush_req = 1;
        cyc();
        idle_in();
        n = 0;
        while (busy && n < 20) begin
            n++;
            if (n == 2) begin
                use_valid = 1; use_set = 0; use_way = 1;
                flush_req = 1;
            end
            cyc();
            idle_in();
        end
        chk("flush_len", n, 8);
        chk("flush_busy_end", int'(busy), 0);
        sweep("flush");
        for (int s = 0; s < 8; s++) begin
            lookup_set = s[2:0];
            #1;
            chk("flush_victim_c", int'(victim_way), 0);
            chk("flush_full_c", int'(set_full), 0);
        end

        for (int w = 0; w < 4; w++) begin
            use_valid = 1; use_set = 6; use_way = w[1:0];
            cyc();
        end
        idle_in();
        flush_req = 1;
        cyc();
        idle_in();
        for (int c = 0; c < 3; c++) cyc();
        chk("abort_busy_pre", int'(busy), 1);
        rst_n = 0;
        m_reset();
        #1;
        chk("abort_busy", int'(busy), 0);
        sweep("abort");
        for (int s = 0; s < 8; s++)
            chk("abort_valid", int'(dut.valid_q[s]), 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("abort_busy_after", int'(busy), 0);
        sweep("after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
